// File: rtl/ram_port_arbiter.sv
// Shares one port of the byte-lane block RAM between instruction fetch (m0) and load/store (m1).
// m1 has fixed priority. A wait counter lets m0 through after MAX_WAIT denied cycles.
module ram_port_arbiter #(
   parameter int DATA_DEPTH = 8192,
   parameter int MAX_WAIT   = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        m0_req_i,
   input  logic [31:0] m0_addr_i,
   input  logic [3:0]  m0_be_i,
   input  logic [31:0] m0_wdata_i,
   input  logic        m1_req_i,
   input  logic [31:0] m1_addr_i,
   input  logic [3:0]  m1_be_i,
   input  logic [31:0] m1_wdata_i,
   output logic        m0_gnt_o,
   output logic        m1_gnt_o,
   output logic        m0_rvalid_o,
   output logic        m1_rvalid_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
   output logic        ram_en_o,
   output logic [3:0]  ram_we_o,
   output logic [31:0] ram_addr_o,
   output logic [31:0] ram_wdata_o,
   input  logic [31:0] ram_rdata_i
);

   localparam int          WW        = $clog2(MAX_WAIT + 1);
   localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
   localparam logic [31:0] DEPTH_W   = 32'(DATA_DEPTH);

   logic [WW-1:0] wait_cnt;
   logic          prio0;
   logic          gnt0;
   logic          gnt1;
   logic          any_gnt;
   logic          in_range;
   logic [31:0]   sel_addr;
   logic [31:0]   sel_wdata;
   logic [3:0]    sel_be;
   logic          rsp_valid;
   logic          rsp_owner;
   logic          rsp_err;

   // Grants are held off while reset is asserted so every RAM-side output reads 0 in reset.
   always_comb begin
      prio0   = (wait_cnt == WAIT_MAX);
      gnt1    = !rst_i && m1_req_i && !(prio0 && m0_req_i);
      gnt0    = !rst_i && m0_req_i && !gnt1;
      any_gnt = gnt0 || gnt1;
   end

   always_comb begin
      sel_addr  = gnt1 ? m1_addr_i  : m0_addr_i;
      sel_wdata = gnt1 ? m1_wdata_i : m0_wdata_i;
      sel_be    = gnt1 ? m1_be_i    : m0_be_i;
      in_range  = ({2'b00, sel_addr[31:2]} < DEPTH_W);
   end

   // RAM write-enable lanes are numbered MSB-first, so the byte enables are bit-reversed.
   always_comb begin
      m0_gnt_o    = gnt0;
      m1_gnt_o    = gnt1;
      ram_en_o    = any_gnt && in_range;
      ram_we_o    = ram_en_o ? {sel_be[0], sel_be[1], sel_be[2], sel_be[3]} : 4'b0000;
      ram_addr_o  = any_gnt ? sel_addr  : 32'h0;
      ram_wdata_o = any_gnt ? sel_wdata : 32'h0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wait_cnt <= '0;
      end else if (gnt0 || !m0_req_i) begin
         wait_cnt <= '0;
      end else if (wait_cnt != WAIT_MAX) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rsp_valid <= 1'b0;
         rsp_owner <= 1'b0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= any_gnt;
         rsp_owner <= gnt1;
         rsp_err   <= any_gnt && !in_range;
      end
   end

   always_comb begin
      m0_rvalid_o = rsp_valid && !rsp_owner;
      m1_rvalid_o = rsp_valid && rsp_owner;
      err_o       = rsp_valid && rsp_err;
      rdata_o     = (rsp_valid && !rsp_err) ? ram_rdata_i : 32'h0;
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM, directed stimulus with a response
// scoreboard checked by an independent monitor.
module tb_ram_port_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        m0_req_i = 1'b0, m1_req_i = 1'b0;
   logic [31:0] m0_addr_i = '0, m1_addr_i = '0;
   logic [3:0]  m0_be_i = '0, m1_be_i = '0;
   logic [31:0] m0_wdata_i = '0, m1_wdata_i = '0;
   logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, err_o, ram_en_o;
   logic [31:0] rdata_o, ram_addr_o, ram_wdata_o;
   logic [3:0]  ram_we_o;
   logic [31:0] ram_rdata_i = '0;

   ram_port_arbiter #(.DATA_DEPTH(8192), .MAX_WAIT(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i),
      .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i),
      .m0_gnt_o(m0_gnt_o), .m1_gnt_o(m1_gnt_o),
      .m0_rvalid_o(m0_rvalid_o), .m1_rvalid_o(m1_rvalid_o),
      .rdata_o(rdata_o), .err_o(err_o),
      .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
      .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   // Read-before-write RAM; we[k] covers bits [8*(3-k)+7 : 8*(3-k)].
   logic [31:0] mem [0:8191];
   always @(posedge clk_i) begin : ram_model
      logic [31:0] w;
      if (ram_en_o) begin
         ram_rdata_i <= mem[ram_addr_o[14:2]];
         w = mem[ram_addr_o[14:2]];
         for (int k = 0; k < 4; k++)
            if (ram_we_o[k]) w[8*(3-k) +: 8] = ram_wdata_o[8*(3-k) +: 8];
         mem[ram_addr_o[14:2]] <= w;
      end
   end

   typedef struct {
      int          cyc;
      logic        owner;
      logic        err;
      logic [31:0] data;
   } rsp_t;

   rsp_t exp_q[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always @(posedge clk_i) cyc++;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Response monitor: every rvalid must match the oldest expected response, in its cycle.
   always @(negedge clk_i) begin
      if (m0_rvalid_o || m1_rvalid_o) begin
         n_cmp++;
         if (m0_rvalid_o && m1_rvalid_o) begin
            n_bad++;
            $display("FAIL rsp_both: both rvalid high (cycle %0d)", cyc);
         end else if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL rsp_unexpected: rvalid m1=%0b with nothing expected (cycle %0d)",
                     m1_rvalid_o, cyc);
         end else begin
            rsp_t e;
            e = exp_q.pop_front();
            if (e.cyc != cyc || m1_rvalid_o !== e.owner || err_o !== e.err || rdata_o !== e.data) begin
               n_bad++;
               $display("FAIL rsp: got cyc=%0d owner=%0b err=%0b data=%h expected cyc=%0d owner=%0b err=%0b data=%h",
                        cyc, m1_rvalid_o, err_o, rdata_o, e.cyc, e.owner, e.err, e.data);
            end
         end
      end
   end

   task automatic drv0(input logic r, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
      m0_req_i = r; m0_addr_i = a; m0_be_i = b; m0_wdata_i = d;
   endtask

   task automatic drv1(input logic r, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
      m1_req_i = r; m1_addr_i = a; m1_be_i = b; m1_wdata_i = d;
   endtask

   // Called at posedge+1 with inputs applied; checks the grant cycle, queues the response.
   task automatic tick(input logic eg0, input logic eg1, input logic een, input logic [3:0] ewe,
                       input logic rsp, input logic eerr, input logic [31:0] edata);
      rsp_t e;
      @(negedge clk_i);
      check32("gnt_en_we", {24'h0, m0_gnt_o, m1_gnt_o, ram_en_o, 1'b0, ram_we_o},
              {24'h0, eg0, eg1, een, 1'b0, ewe});
      if (een) begin
         check32("ram_addr",  ram_addr_o,  eg1 ? m1_addr_i  : m0_addr_i);
         check32("ram_wdata", ram_wdata_o, eg1 ? m1_wdata_i : m0_wdata_i);
      end
      if (rsp && (eg0 || eg1)) begin
         e.cyc = cyc + 1; e.owner = eg1; e.err = eerr; e.data = edata;
         exp_q.push_back(e);
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      drv0(1'b0, 32'h0, 4'h0, 32'h0);
      drv1(1'b0, 32'h0, 4'h0, 32'h0);
      tick(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic check_reset_state(input string name);
      check32({name, "_flags"},
              {24'h0, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, err_o, ram_en_o, 2'b00},
              32'h0);
      check32({name, "_we"},    {28'h0, ram_we_o}, 32'h0);
      check32({name, "_rdata"}, rdata_o, 32'h0);
      check32({name, "_addr"},  ram_addr_o, 32'h0);
      check32({name, "_wdata"}, ram_wdata_o, 32'h0);
      check32({name, "_wait"},  32'(dut.wait_cnt), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 8192; i++) mem[i] = 32'hC0DE0000 | i;
      mem[4] = 32'hA1B2C3D4;
      mem[8] = 32'h11223344;

      // Requests held during reset must not be granted.
      drv0(1'b1, 32'h40, 4'h0, 32'h0);
      drv1(1'b1, 32'h44, 4'h0, 32'h0);
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check_reset_state("reset");
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      drv0(1'b0, 32'h0, 4'h0, 32'h0);
      drv1(1'b0, 32'h0, 4'h0, 32'h0);
      tick(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0);

      // Basic m1 read.
      drv1(1'b1, 32'h10, 4'h0, 32'h0);
      tick(1'b0, 1'b1, 1'b1, 4'h0, 1'b1, 1'b0, 32'hA1B2C3D4);
      idle();

      // m0 byte write then read-back: pre-write word returned on the write.
      drv0(1'b1, 32'h20, 4'b0001, 32'h000000EE);
      tick(1'b1, 1'b0, 1'b1, 4'b1000, 1'b1, 1'b0, 32'h11223344);
      drv0(1'b1, 32'h20, 4'b0000, 32'h0);
      tick(1'b1, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 32'h112233EE);

      // Continuous contention: m1 x4 then m0, repeating.
      drv0(1'b1, 32'h40, 4'h0, 32'h0);
      drv1(1'b1, 32'h44, 4'h0, 32'h0);
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 4; k++)
            tick(1'b0, 1'b1, 1'b1, 4'h0, 1'b1, 1'b0, 32'hC0DE0011);
         tick(1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 32'hC0DE0010);
      end
      idle();

      // Address range boundaries, reads and a rejected write.
      drv1(1'b1, 32'h8000, 4'h0, 32'h0);
      tick(1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 32'h0);
      drv1(1'b1, 32'h7FFC, 4'h0, 32'h0);
      tick(1'b0, 1'b1, 1'b1, 4'h0, 1'b1, 1'b0, 32'hC0DE1FFF);
      drv1(1'b0, 32'h0, 4'h0, 32'h0);
      drv0(1'b1, 32'hFFFFFFFC, 4'h0, 32'h0);
      tick(1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 32'h0);
      drv0(1'b0, 32'h0, 4'h0, 32'h0);
      drv1(1'b1, 32'h8000, 4'hF, 32'hDEADBEEF);
      tick(1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 32'h0);

      // Sparse byte-enable write from m1, then read back.
      drv1(1'b1, 32'h44, 4'b1010, 32'hAABBCCDD);
      tick(1'b0, 1'b1, 1'b1, 4'b0101, 1'b1, 1'b0, 32'hC0DE0011);
      drv1(1'b1, 32'h44, 4'b0000, 32'h0);
      tick(1'b0, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 32'hAADECC11);
      idle();

      // Alternating masters, one response per cycle.
      drv0(1'b1, 32'h04, 4'h0, 32'h0); drv1(1'b0, 32'h0, 4'h0, 32'h0);
      tick(1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 32'hC0DE0001);
      drv0(1'b0, 32'h0, 4'h0, 32'h0);  drv1(1'b1, 32'h08, 4'h0, 32'h0);
      tick(1'b0, 1'b1, 1'b1, 4'h0, 1'b1, 1'b0, 32'hC0DE0002);
      drv0(1'b1, 32'h0C, 4'h0, 32'h0); drv1(1'b0, 32'h0, 4'h0, 32'h0);
      tick(1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 32'hC0DE0003);
      drv0(1'b0, 32'h0, 4'h0, 32'h0);  drv1(1'b1, 32'h10, 4'h0, 32'h0);
      tick(1'b0, 1'b1, 1'b1, 4'h0, 1'b1, 1'b0, 32'hA1B2C3D4);
      idle();

      // Reset in the cycle after an m0 grant drops the in-flight response.
      drv0(1'b1, 32'h40, 4'h0, 32'h0);
      tick(1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 32'h0);
      rst_i = 1'b1;
      #2;
      check_reset_state("midrst");
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      drv0(1'b0, 32'h0, 4'h0, 32'h0);
      drv1(1'b1, 32'h10, 4'h0, 32'h0);
      tick(1'b0, 1'b1, 1'b1, 4'h0, 1'b1, 1'b0, 32'hA1B2C3D4);
      idle();
      idle();

      check32("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-master arbiter that shares one port of the dual-port byte-lane block RAM between the instruction-fetch unit (master 0) and the load/store unit (master 1). It grants at most one request per cycle, drives the RAM enable, write-enable, address and write data, rejects out-of-range addresses, and routes the RAM's one-cycle-latency read data back to the owning master. Master 1 has fixed priority, bounded by a starvation counter that guarantees master 0 progress.

## Interface
- DATA_DEPTH, 8192: RAM depth in 32-bit words; valid byte addresses are 0 .. DATA_DEPTH*4-1.
- MAX_WAIT, 4: consecutive denied cycles after which master 0 takes priority; must be ≥1.

- clk_i  in  1  clock; the RAM port clock is driven from the same net
- rst_i  in  1  asynchronous, active-high reset
- m0_req_i / m1_req_i  in  1  request valid; held until granted
- m0_addr_i / m1_addr_i  in  32  byte address; bits [1:0] forwarded unchanged, ignored by the RAM
- m0_be_i / m1_be_i  in  4  byte write enables, be[n] writes wdata[8n+7:8n]; 0 means read
- m0_wdata_i / m1_wdata_i  in  32  write data
- m0_gnt_o / m1_gnt_o  out  1  request accepted this cycle (combinational)
- m0_rvalid_o / m1_rvalid_o  out  1  response valid, exactly one cycle after grant
- rdata_o  out  32  shared response data, valid when either rvalid is high
- err_o  out  1  response is an address error, qualified by rvalid
- ram_en_o  out  1  RAM port enable
- ram_we_o  out  4  RAM write enables: we[0]→bits 31:24, we[1]→23:16, we[2]→15:8, we[3]→7:0
- ram_addr_o  out  32  RAM byte address
- ram_wdata_o  out  32  RAM write data
- ram_rdata_i  in  32  RAM registered read data

## Operation
- Arbitration, per cycle:
  - prio0 = (wait_cnt == MAX_WAIT).
  - Master 1 granted if m1_req_i and not (prio0 and m0_req_i).
  - Otherwise master 0 granted if m0_req_i.
  - Exactly zero or one gnt high per cycle.
- wait_cnt, width $clog2(MAX_WAIT+1):
  - Increments, saturating at MAX_WAIT, when m0_req_i is high and m0_gnt_o is low.
  - Clears on m0_gnt_o or when m0_req_i is low.
- Grant to an in-range address (addr[31:2] < DATA_DEPTH):
  - ram_en_o = 1, ram_addr_o = addr, ram_wdata_o = wdata.
  - ram_we_o = bit-reversed be, i.e. ram_we_o[3-n] = be[n].
- Grant to an out-of-range address:
  - ram_en_o = 0, ram_we_o = 0.
  - The request is still granted and consumed.
- No grant: ram_en_o = 0 and ram_we_o = 0. ram_addr_o and ram_wdata_o are don't-care.
- Response tracking registers, cleared by reset:
  - rsp_valid: set by any grant.
  - rsp_owner: the granted master, 0 or 1.
  - rsp_err: the out-of-range flag.
- Response, cycle after grant:
  - mX_rvalid_o = rsp_valid and (rsp_owner == X).
  - rdata_o = rsp_err ? 0 : ram_rdata_i. Unqualified when no rvalid is high.
  - err_o = rsp_valid and rsp_err.
- Write responses: rvalid pulses as an acknowledgement. rdata_o carries the pre-write word, because the RAM reads before it writes; masters ignore it.
- Back-to-back grants every cycle are permitted. Responses stay in grant order, one per cycle.

## Timing
- Reset values: all gnt, rvalid, err_o, ram_en_o and ram_we_o are 0. rdata_o, ram_addr_o and ram_wdata_o are 0. wait_cnt = 0.
- Reset asserted mid-operation: any in-flight response is dropped, so no rvalid follows. The first grant is possible in the first cycle after rst_i deasserts.
- Latency: request seen in cycle N → gnt in cycle N → RAM samples at the end of N → rvalid and rdata in cycle N+1.
- gnt_o is combinational from req_i and wait_cnt. There is no combinational path from ram_rdata_i to any gnt.
- Simultaneous requests: master 1 wins unless prio0. With both requesting continuously, master 0 is granted once every MAX_WAIT+1 cycles.
- A master drops or changes req only after its gnt. Changing an ungranted request is illegal, and the arbiter does not check it.

## Test plan
- Reset, then m1 reads addr 0x10 (RAM word 4 = 0xA1B2C3D4) → m1_gnt same cycle, ram_en_o=1, ram_we_o=0; next cycle m1_rvalid=1, rdata_o=0xA1B2C3D4, err_o=0.
- m0 writes addr 0x20 with be=4'b0001 and wdata=0x000000EE → ram_we_o=4'b1000. Then m0 reads 0x20 → low byte = 0xEE and the upper bytes are unchanged.
- Both masters request continuously with MAX_WAIT=4 → grant sequence m1,m1,m1,m1,m0 repeating. Each rvalid goes to the correct owner one cycle after its grant.
- m1 reads addr 0x8000 (= DATA_DEPTH*4) → gnt=1, ram_en_o=0; next cycle m1_rvalid=1, err_o=1, rdata_o=0.
- Assert rst_i in the cycle after an m0 grant → m0_rvalid stays 0, and all outputs and wait_cnt return to 0 asynchronously.
- Alternate m0 and m1 reads on consecutive cycles → one rvalid per cycle, in grant order, with no bubbles.
